// File: rtl/multi_channel_prescale_counter_if.sv
// Bus bundle for multi_channel_prescale_counter: select, enable, divide
// ratios, clears in; counts, ticks, overflow flags out.
//   Slt   channel select          En    count enable
//   Div   per-channel ratios      Clr   per-channel clear
//   Count per-channel counters    Tick  terminal pulses
//   Ovf   sticky overflow flags
interface multi_channel_prescale_counter_if #(
    parameter int CHANNELS   = 2,
    parameter int SEL_W      = 1,
    parameter int PRESCALE_W = 3,
    parameter int CNT_W      = 64
);
    logic [SEL_W-1:0]               Slt;
    logic                           En;
    logic [CHANNELS*PRESCALE_W-1:0] Div;
    logic [CHANNELS-1:0]            Clr;
    logic [CHANNELS*CNT_W-1:0]      Count;
    logic [CHANNELS-1:0]            Tick;
    logic [CHANNELS-1:0]            Ovf;

    modport master (
        output Slt, En, Div, Clr,
        input  Count, Tick, Ovf
    );

    modport slave (
        input  Slt, En, Div, Clr,
        output Count, Tick, Ovf
    );
endinterface

// File: rtl/multi_channel_prescale_counter.sv
// N-channel prescaled event counter: the selected, enabled channel advances
// its prescaler; every D-th hit bumps its wide counter and pulses Tick.
//   Clk   system clock (rising edge)
//   Reset asynchronous active-high reset
//   bus   slave side of multi_channel_prescale_counter_if
module multi_channel_prescale_counter #(
    parameter int CHANNELS   = 2,
    parameter int SEL_W      = 1,
    parameter int PRESCALE_W = 3,
    parameter int CNT_W      = 64,
    parameter int WRAP       = 1
) (
    input logic Clk,
    input logic Reset,
    multi_channel_prescale_counter_if.slave bus
);
    localparam logic [CNT_W-1:0] ONES = '1;

    logic [CHANNELS*CNT_W-1:0] count_w;
    logic [CHANNELS-1:0]       tick_w;
    logic [CHANNELS-1:0]       ovf_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PRESCALE_W-1:0] pre_q;
        logic [CNT_W-1:0]      cnt_q;
        logic                  tick_q;
        logic                  ovf_q;

        logic [PRESCALE_W-1:0] div_i;
        logic [PRESCALE_W-1:0] last;
        logic [CNT_W-1:0]      cnt_inc;
        logic                  hit;
        logic                  term;

        assign div_i   = bus.Div[i*PRESCALE_W +: PRESCALE_W];
        // Ratio 0 behaves as 1, so the last prescaler value is 0 either way.
        assign last    = (div_i == '0) ? '0 : div_i - PRESCALE_W'(1);
        assign cnt_inc = cnt_q + CNT_W'(1);
        assign hit     = bus.En && (bus.Slt == SEL_W'(i));
        // ">=" so a ratio lowered below the current prescaler ends at once.
        assign term    = hit && (pre_q >= last);

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                pre_q  <= '0;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (bus.Clr[i]) begin
                pre_q  <= '0;
                cnt_q  <= '0;
                tick_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (term) begin
                pre_q  <= '0;
                tick_q <= 1'b1;
                if (cnt_q == ONES) begin
                    if (WRAP != 0) begin
                        cnt_q <= '0;
                        ovf_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_inc;
                    // Saturating mode flags the edge that first reaches max.
                    if (WRAP == 0 && cnt_inc == ONES) begin
                        ovf_q <= 1'b1;
                    end
                end
            end else if (hit) begin
                pre_q  <= pre_q + PRESCALE_W'(1);
                tick_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign count_w[i*CNT_W +: CNT_W] = cnt_q;
        assign tick_w[i]                 = tick_q;
        assign ovf_w[i]                  = ovf_q;
    end

    assign bus.Count = count_w;
    assign bus.Tick  = tick_w;
    assign bus.Ovf   = ovf_w;
endmodule

// File: tb/tb_multi_channel_prescale_counter.sv
// Bench for multi_channel_prescale_counter: three instances (64-bit wrap,
// 4-bit wrap, 4-bit saturate) share one stimulus and one reference model.
module tb_multi_channel_prescale_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] slt = '0;
    logic       en  = 1'b0;
    logic [8:0] div = '0;
    logic [2:0] clr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_channel_prescale_counter_if #(
        .CHANNELS(3), .SEL_W(2), .PRESCALE_W(3), .CNT_W(64)
    ) if0 ();
    multi_channel_prescale_counter_if #(
        .CHANNELS(3), .SEL_W(2), .PRESCALE_W(3), .CNT_W(4)
    ) if1 ();
    multi_channel_prescale_counter_if #(
        .CHANNELS(3), .SEL_W(2), .PRESCALE_W(3), .CNT_W(4)
    ) if2 ();

    assign if0.Slt = slt; assign if0.En = en;
    assign if0.Div = div; assign if0.Clr = clr;
    assign if1.Slt = slt; assign if1.En = en;
    assign if1.Div = div; assign if1.Clr = clr;
    assign if2.Slt = slt; assign if2.En = en;
    assign if2.Div = div; assign if2.Clr = clr;

    multi_channel_prescale_counter #(
        .CHANNELS(3), .SEL_W(2), .PRESCALE_W(3), .CNT_W(64), .WRAP(1)
    ) u0 (.Clk(clk), .Reset(rst), .bus(if0.slave));
    multi_channel_prescale_counter #(
        .CHANNELS(3), .SEL_W(2), .PRESCALE_W(3), .CNT_W(4), .WRAP(1)
    ) u1 (.Clk(clk), .Reset(rst), .bus(if1.slave));
    multi_channel_prescale_counter #(
        .CHANNELS(3), .SEL_W(2), .PRESCALE_W(3), .CNT_W(4), .WRAP(0)
    ) u2 (.Clk(clk), .Reset(rst), .bus(if2.slave));

    // DUT outputs gathered per [instance][channel]
    logic [63:0] a_cnt [3][3];
    logic        a_tick[3][3];
    logic        a_ovf [3][3];

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            a_cnt[0][c]  = if0.Count[c*64 +: 64];
            a_cnt[1][c]  = {60'd0, if1.Count[c*4 +: 4]};
            a_cnt[2][c]  = {60'd0, if2.Count[c*4 +: 4]};
            a_tick[0][c] = if0.Tick[c];
            a_tick[1][c] = if1.Tick[c];
            a_tick[2][c] = if2.Tick[c];
            a_ovf[0][c]  = if0.Ovf[c];
            a_ovf[1][c]  = if1.Ovf[c];
            a_ovf[2][c]  = if2.Ovf[c];
        end
    end

    function automatic logic [63:0] cmax(input int k);
        return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hF;
    endfunction

    function automatic bit wraps(input int k);
        return k != 2;
    endfunction

    // Reference model: prescaler as an integer hit count, counter as a
    // bounded integer with explicit wrap/saturate arithmetic.
    logic [63:0] m_cnt [3][3];
    int          m_pre [3][3];
    logic        m_tick[3][3];
    logic        m_ovf [3][3];

    always @(posedge clk or posedge rst) begin : model
        int d;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                d = int'(div[c*3 +: 3]);
                if (d == 0) d = 1;
                if (rst || clr[c]) begin
                    m_cnt[k][c]  = 64'd0;
                    m_pre[k][c]  = 0;
                    m_tick[k][c] = 1'b0;
                    m_ovf[k][c]  = 1'b0;
                end else if (en && int'(slt) == c) begin
                    if (m_pre[k][c] + 1 >= d) begin
                        m_pre[k][c]  = 0;
                        m_tick[k][c] = 1'b1;
                        if (m_cnt[k][c] == cmax(k)) begin
                            if (wraps(k)) begin
                                m_cnt[k][c] = 64'd0;
                                m_ovf[k][c] = 1'b1;
                            end
                        end else begin
                            m_cnt[k][c] = m_cnt[k][c] + 64'd1;
                            if (!wraps(k) && m_cnt[k][c] == cmax(k))
                                m_ovf[k][c] = 1'b1;
                        end
                    end else begin
                        m_pre[k][c]  = m_pre[k][c] + 1;
                        m_tick[k][c] = 1'b0;
                    end
                end else begin
                    m_tick[k][c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("model cnt[%0d][%0d]", k, c),
                      a_cnt[k][c], m_cnt[k][c]);
                check($sformatf("model tick[%0d][%0d]", k, c),
                      64'(a_tick[k][c]), 64'(m_tick[k][c]));
                check($sformatf("model ovf[%0d][%0d]", k, c),
                      64'(a_ovf[k][c]), 64'(m_ovf[k][c]));
            end
        end
    end

    task automatic hit(input logic [1:0] s, input logic e);
        slt = s;
        en  = e;
        @(negedge clk);
    endtask

    task automatic set_div(input int c, input logic [2:0] v);
        div[c*3 +: 3] = v;
    endtask

    initial begin
        set_div(0, 3'd1);
        set_div(1, 3'd4);
        set_div(2, 3'd1);
        repeat (2) @(negedge clk);
        check("reset cnt0", a_cnt[0][0], 64'd0);
        check("reset ovf2_0", 64'(a_ovf[2][0]), 64'd0);
        rst = 1'b0;

        // D0=1: one count per hit
        for (int i = 1; i <= 3; i++) begin
            hit(2'd0, 1'b1);
            check("d1 tick0", 64'(a_tick[0][0]), 64'd1);
        end
        check("d1 cnt0", a_cnt[0][0], 64'd3);

        // D1=4: ticks after 4th and 8th hit
        for (int i = 1; i <= 8; i++) begin
            hit(2'd1, 1'b1);
            check("d4 tick1", 64'(a_tick[0][1]), 64'(i % 4 == 0));
        end
        check("d4 cnt1", a_cnt[0][1], 64'd2);

        // gaps in En do not advance the prescaler
        hit(2'd1, 1'b1); hit(2'd1, 1'b0); hit(2'd1, 1'b1);
        hit(2'd1, 1'b1); hit(2'd1, 1'b0);
        check("gap cnt1 pre", a_cnt[0][1], 64'd2);
        hit(2'd1, 1'b1);
        check("gap cnt1 post", a_cnt[0][1], 64'd3);
        check("gap tick1", 64'(a_tick[0][1]), 64'd1);

        // async reset with pre1=3
        repeat (3) hit(2'd1, 1'b1);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async cnt1", a_cnt[0][1], 64'd0);
        check("async cnt0", a_cnt[0][0], 64'd0);
        check("async ovf", 64'({if0.Ovf, if1.Ovf, if2.Ovf}), 64'd0);
        check("async tick", 64'({if0.Tick, if1.Tick, if2.Tick}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            hit(2'd1, 1'b1);
            check("post-rst tick1", 64'(a_tick[0][1]), 64'(i == 4));
        end
        check("post-rst cnt1", a_cnt[0][1], 64'd1);

        // 4-bit wrap vs saturate on channel 0, D=1
        for (int i = 1; i <= 16; i++) begin
            hit(2'd0, 1'b1);
            check("wrap cnt", a_cnt[1][0], 64'(i % 16));
            check("wrap ovf", 64'(a_ovf[1][0]), 64'(i == 16));
            check("sat cnt", a_cnt[2][0], 64'(i < 15 ? i : 15));
            check("sat ovf", 64'(a_ovf[2][0]), 64'(i >= 15));
            check("sat tick", 64'(a_tick[2][0]), 64'd1);
        end
        check("wide cnt0", a_cnt[0][0], 64'd16);

        // clear beats a simultaneous terminal hit
        repeat (16) hit(2'd1, 1'b1);
        check("clr pre cnt1", a_cnt[0][1], 64'd5);
        clr = 3'b001;
        hit(2'd0, 1'b1);
        clr = 3'b000;
        check("clr cnt0", a_cnt[0][0], 64'd0);
        check("clr tick0", 64'(a_tick[0][0]), 64'd0);
        check("clr ovf0", 64'(a_ovf[2][0]), 64'd0);
        check("clr cnt1 kept", a_cnt[0][1], 64'd5);

        // Div lowered 4->2 with pre1=3, then Div=0 acts as 1
        repeat (3) hit(2'd1, 1'b1);
        set_div(1, 3'd2);
        hit(2'd1, 1'b1);
        check("div drop cnt1", a_cnt[0][1], 64'd6);
        check("div drop tick1", 64'(a_tick[0][1]), 64'd1);
        hit(2'd1, 1'b1);
        check("div2 no tick", 64'(a_tick[0][1]), 64'd0);
        hit(2'd1, 1'b1);
        check("div2 cnt1", a_cnt[0][1], 64'd7);
        set_div(1, 3'd0);
        hit(2'd1, 1'b1);
        hit(2'd1, 1'b1);
        check("div0 cnt1", a_cnt[0][1], 64'd9);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            slt = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 7) == 0)
                    set_div(c, 3'($urandom_range(0, 7)));
                clr[c] = ($urandom_range(0, 31) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        clr = '0;
        en  = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
